phy_tx_arb_ctrl: RTL and testbench
==================================

// Module: phy_tx_arb_ctrl
// PURPOSE
//  Round-robin scheduler that shares the single 8b10b TX encoder path among NREQ arbitration queues.
//  Grants one queue at a time, pops exactly count_in words from it, then rotates priority.
//  Presents a valid/ready word stream plus a last-word flag to the encoder front end.
//  Sits between the per-lane arb_que_if queues and the encoder wrapper.
// PARAMETERS
//  NBITS  8  data word width (matches arb_que_if NBITS)
//  NREQ   4  number of requester queues (2..8)
// PORTS
//  CLK        in   1              clock
//  nRST       in   1              async active-low reset
//  clear      in   1              sync flush: abort transfer, return to IDLE
//  req        in   NREQ           queue i holds a packet ready to send
//  req_cnt    in   NREQ*4         packet length in words per queue (1..15)
//  req_data   in   NREQ*NBITS     head word of each queue (que_out)
//  que_dec    out  NREQ           one-hot pop strobe to granted queue (drives dec)
//  que_clear  out  NREQ           per-queue clear, pulsed on abort of granted queue
//  out_data   out  NBITS          word to encoder
//  out_valid  out  1              out_data valid
//  out_last   out  1              final word of packet (with out_valid)
//  out_ready  in   1              encoder accepts word this cycle
//  grant_id   out  $clog2(NREQ)   index of current owner
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, remaining=0, grant_id=0; all outputs 0.
//  Eligibility: req[i] && req_cnt[i]!=0. Zero-count requests are never granted.
//  FSM (states IDLE, LOAD, SEND):
//   IDLE: if any eligible, rr pick from rr_ptr (inclusive) upward, wrapping -> latch grant_id.
//    Latch remaining=req_cnt[grant] -> LOAD. Else stay.
//   LOAD: one-cycle settle for queue head; -> SEND. out_valid=0.
//   SEND: out_valid=1, out_data=req_data[grant_id], out_last=(remaining==1).
//    On out_valid&&out_ready: que_dec[grant_id]=1 same cycle, remaining-=1.
//    If remaining was 1 -> IDLE, rr_ptr=(grant_id+1) mod NREQ.
//  Latency: req asserted in IDLE -> first out_valid 2 cycles later.
//  Back-to-back packets: 1 IDLE + 1 LOAD bubble between packets.
//  Stall: out_ready=0 holds out_data/out_last stable; no que_dec.
//  req/req_cnt of the granted queue are ignored after latch. Deassertion mid-packet does not abort.
//  clear (any state): next state IDLE, remaining=0, que_dec=0.
//   If state was LOAD/SEND, que_clear[grant_id] pulses 1 cycle; rr_ptr advances past grant_id.
//   clear has priority over a simultaneous handshake: no que_dec that cycle.
//  que_dec and que_clear are one-hot-or-zero, never both set.
//  nRST mid-packet: immediate return to reset values; queues are not cleared.
//  remaining is 4-bit unsigned; never decremented below 1 while in SEND.
// STRUCTURE
//  phy_types_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_SEND} arb_state_t;
//   localparam ARB_CNT_W=4.
//  Sub-module rr_arbiter #(NREQ): inputs elig, rr_ptr; outputs gnt_valid, gnt_idx. Combinational.
//  Top holds FSM, remaining counter, rr_ptr register and output muxing.
// TESTING
//  1 Single pkt: req[2]=1, cnt=3, out_ready=1.
//    -> 3 words from q2, out_last on 3rd, 3 que_dec[2] pulses, busy low after, rr_ptr=3.
//  2 RR fairness: all 4 req, cnt=1, rr_ptr=0 -> grant order 0,1,2,3,0; 1-word pkts spaced 3 cycles.
//  3 Backpressure: cnt=2, out_ready toggled 0,0,1,0,1.
//    -> data/last stable while stalled; exactly 2 que_dec; none while out_ready=0.
//  4 Zero count: req[1]=1 cnt=0 and req[3]=1 cnt=1 -> q3 granted, q1 never granted.
//  5 Clear mid-SEND: cnt=5, clear after 2nd word accepted with out_ready=1.
//    -> no dec that cycle, que_clear[g] pulse, IDLE next cycle, rr_ptr=g+1.
//  6 Reset mid-SEND: nRST low for 1 cycle during word 2 of 4.
//    -> all outputs 0 async, rr_ptr=0, fresh grant after release.

Source files
------------

// File: rtl/phy_types_pkg.sv
// Shared types for the PHY TX arbitration path.
package phy_types_pkg;

  localparam int unsigned ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_SEND = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    gnt_valid,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!gnt_valid && elig[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/phy_tx_arb_ctrl.sv
// Round-robin scheduler sharing the 8b10b TX encoder among NREQ queues;
// grants one queue, streams its packet word by word, then rotates priority.
module phy_tx_arb_ctrl
  import phy_types_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ARB_CNT_W-1:0] req_cnt,
  input  logic [NREQ*NBITS-1:0]     req_data,
  output logic [NREQ-1:0]           que_dec,
  output logic [NREQ-1:0]           que_clear,
  output logic [NBITS-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int unsigned GW = $clog2(NREQ);

  arb_state_t           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [ARB_CNT_W-1:0] rem_q, rem_d;

  logic [ARB_CNT_W-1:0] cnt_a  [NREQ];
  logic [NBITS-1:0]     data_a [NREQ];
  logic [NREQ-1:0]      elig;
  logic                 gnt_valid;
  logic [GW-1:0]        gnt_idx;

  function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] g);
    return (g == GW'(NREQ - 1)) ? '0 : g + GW'(1);
  endfunction

  // Unpack per-queue fields; zero-length packets are never eligible.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_a[i]  = req_cnt[i*ARB_CNT_W +: ARB_CNT_W];
      data_a[i] = req_data[i*NBITS +: NBITS];
      elig[i]   = req[i] && (cnt_a[i] != '0);
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .elig      (elig),
    .rr_ptr    (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and output decode; clear overrides any handshake.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    rem_d     = rem_q;
    que_dec   = '0;
    que_clear = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;

    if (state_q == ARB_SEND) begin
      out_valid = 1'b1;
      out_data  = data_a[grant_q];
      out_last  = (rem_q == ARB_CNT_W'(1));
    end

    if (clear) begin
      state_d = ARB_IDLE;
      rem_d   = '0;
      if (state_q != ARB_IDLE) begin
        que_clear[grant_q] = 1'b1;
        rr_d               = ptr_after(grant_q);
      end
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (gnt_valid) begin
            grant_d = gnt_idx;
            rem_d   = cnt_a[gnt_idx];
            state_d = ARB_LOAD;
          end
        end
        ARB_LOAD: state_d = ARB_SEND;
        ARB_SEND: begin
          if (out_ready) begin
            que_dec[grant_q] = 1'b1;
            rem_d            = rem_q - ARB_CNT_W'(1);
            if (rem_q <= ARB_CNT_W'(1)) begin
              state_d = ARB_IDLE;
              rem_d   = '0;
              rr_d    = ptr_after(grant_q);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_phy_tx_arb_ctrl.sv
// Bench for phy_tx_arb_ctrl: directed scenarios plus randomized traffic against a packet-level model.
module tb_phy_tx_arb_ctrl;

  localparam int NB = 8;
  localparam int NQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [NQ-1:0]     req = '0;
  logic [NQ*4-1:0]   req_cnt = '0;
  logic [NQ*NB-1:0]  req_data = '0;
  logic              out_ready = 1'b0;
  logic [NQ-1:0]     que_dec, que_clear;
  logic [NB-1:0]     out_data;
  logic              out_valid, out_last, busy;
  logic [1:0]        grant_id;

  phy_tx_arb_ctrl #(.NBITS(NB), .NREQ(NQ)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req(req), .req_cnt(req_cnt),
    .req_data(req_data), .que_dec(que_dec), .que_clear(que_clear),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Packet-level model: owner = -1 when no packet is in flight.
  int m_owner, m_settle, m_left, m_ptr, m_gid;
  int cyc, n_dec, n_end;
  int done_q[$];
  int vcyc_q[$];

  task automatic model_reset();
    m_owner = -1; m_settle = 0; m_left = 0; m_ptr = 0; m_gid = 0;
  endtask

  function automatic int cnt_of(input int i);
    logic [NQ*4-1:0] v;
    v = req_cnt;
    return int'(v[i*4 +: 4]);
  endfunction

  function automatic logic [NB-1:0] data_of(input int i);
    logic [NQ*NB-1:0] v;
    v = req_data;
    return v[i*NB +: NB];
  endfunction

  task automatic compare_outputs();
    bit sending;
    logic [NQ-1:0] e_dec, e_clr;
    sending = (m_owner >= 0) && (m_settle == 0);
    e_dec = '0; e_clr = '0;
    if (sending && out_ready && !clear) e_dec[m_owner] = 1'b1;
    if (clear && m_owner >= 0) e_clr[m_owner] = 1'b1;
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("valid", 32'(out_valid), 32'(sending));
    check("data", 32'(out_data), sending ? 32'(data_of(m_owner)) : 32'd0);
    check("last", 32'(out_last), 32'(sending && m_left == 1));
    check("que_dec", 32'(que_dec), 32'(e_dec));
    check("que_clear", 32'(que_clear), 32'(e_clr));
    check("grant_id", 32'(grant_id), 32'(m_gid));
  endtask

  task automatic model_step();
    if (clear) begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % NQ;
      m_owner = -1; m_left = 0; m_settle = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NQ; k++) begin
        int j;
        j = (m_ptr + k) % NQ;
        if (m_owner < 0 && req[j] && cnt_of(j) != 0) begin
          m_owner = j; m_gid = j; m_left = cnt_of(j); m_settle = 1;
        end
      end
    end else if (m_settle != 0) begin
      m_settle = 0;
    end else if (out_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ptr = (m_owner + 1) % NQ;
        m_owner = -1;
      end
    end
  endtask

  // One clock: check at negedge, advance model, return at posedge+1 for new stimulus.
  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    if (que_dec != '0) n_dec++;
    if (out_valid) vcyc_q.push_back(cyc);
    if (out_valid && out_ready && out_last && !clear) begin
      n_end++;
      done_q.push_back(int'(grant_id));
    end
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_cnt(input int q, input int c);
    req_cnt[q*4 +: 4] = 4'(c);
  endtask

  task automatic clr_logs();
    n_dec = 0; n_end = 0; done_q.delete(); vcyc_q.delete();
  endtask

  initial begin
    model_reset();
    cyc = 0;
    clr_logs();
    for (int q = 0; q < NQ; q++) req_data[q*NB +: NB] = NB'(8'h10 * (q + 1) + 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_gid", 32'(grant_id), 0);
    rst_n = 1'b1;

    // Single packet from q2, 3 words.
    clr_logs();
    req = 4'b0100; set_cnt(2, 3); out_ready = 1'b1;
    cycle();
    req = '0;
    run(6);
    check("t1_decs", 32'(n_dec), 3);
    check("t1_ends", 32'(n_end), 1);
    check("t1_idle", 32'(busy), 0);
    // Pointer now sits at 3: next grant among all goes to q3; abort it in LOAD.
    req = 4'b1111; for (int q = 0; q < NQ; q++) set_cnt(q, 1);
    cycle();
    check("t1_rrptr", 32'(grant_id), 3);
    clear = 1'b1; req = '0;
    cycle();
    clear = 1'b0;
    run(2);

    // Round-robin fairness, 1-word packets.
    clr_logs();
    req = 4'b1111;
    run(16);
    req = '0;
    run(4);
    check("t2_count", 32'(done_q.size() >= 5), 1);
    for (int i = 0; i < 5 && i < done_q.size(); i++) begin
      int exp_g[5] = '{0, 1, 2, 3, 0};
      check("t2_order", 32'(done_q[i]), 32'(exp_g[i]));
    end
    for (int i = 1; i < 5 && i < vcyc_q.size(); i++)
      check("t2_spacing", 32'(vcyc_q[i] - vcyc_q[i-1]), 3);

    // Backpressure on a 2-word packet from q0.
    clr_logs();
    req = 4'b0001; set_cnt(0, 2); out_ready = 1'b0;
    cycle();
    req = '0;
    cycle();
    begin
      bit pat[5] = '{0, 0, 1, 0, 1};
      for (int i = 0; i < 5; i++) begin
        out_ready = pat[i];
        cycle();
      end
    end
    out_ready = 1'b1;
    run(2);
    check("t3_decs", 32'(n_dec), 2);
    check("t3_idle", 32'(busy), 0);

    // Zero-count requester is never served.
    clr_logs();
    req = 4'b1010; set_cnt(1, 0); set_cnt(3, 1);
    run(10);
    req = '0;
    run(3);
    check("t4_served", 32'(done_q.size() >= 2), 1);
    foreach (done_q[i]) check("t4_owner", 32'(done_q[i]), 3);

    // Clear after second word of a 5-word packet from q1.
    clr_logs();
    req = 4'b0010; set_cnt(1, 5);
    cycle();
    req = '0;
    run(3);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
    check("t5_decs", 32'(n_dec), 2);
    check("t5_idle", 32'(busy), 0);
    req = 4'b1111; for (int q = 0; q < NQ; q++) set_cnt(q, 1);
    cycle();
    check("t5_rrptr", 32'(grant_id), 2);
    req = '0;
    run(5);

    // Async reset during word 2 of 4 from q2.
    req = 4'b0100; set_cnt(2, 4);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_dec", 32'(que_dec), 0);
    check("t6_gid", 32'(grant_id), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_logs();
    run(8);
    req = '0;
    run(3);
    check("t6_fresh", 32'(n_end), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req = 4'($urandom);
      for (int q = 0; q < NQ; q++)
        set_cnt(q, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)));
      req_data = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 40) == 0);
      cycle();
    end
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
